// File: rtl/serial_tx.sv
// serial_tx: framed serial transmitter.
//   Accepts a parallel word through a valid/ready handshake and shifts it out
//   on one line as: start bit (0), data bits LSB-first, [parity], stop bit (1).
//   Every bit is held for CLKS_PER_BIT clock cycles. All outputs are registered.
//
// Optional feature macro: SERIAL_TX_PARITY_EN
//   When defined, an even-parity bit (XOR of the accepted word) is sent
//   between the last data bit and the stop bit.
//
// Ports:
//   clk        clock, all state changes on its rising edge
//   reset_n    synchronous active-low reset
//   tx_data    word to send, captured at the handshake edge
//   tx_valid   producer has a word on tx_data
//   tx_ready   block can accept a word (registered)
//   tx_serial  serial line, idles high (registered)
//   busy       frame in progress (registered)
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state, state_n;
  logic [CNT_W-1:0]  clk_cnt, clk_cnt_n;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] shift_reg, shift_reg_n;
  logic [DATA_W-1:0] shift_nxt;
  logic              serial_n, ready_n, busy_n;
  logic              bit_done;
`ifdef SERIAL_TX_PARITY_EN
  logic              par_bit, par_bit_n;
`endif

  assign bit_done  = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign shift_nxt = shift_reg >> 1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
      busy      <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      clk_cnt   <= clk_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shift_reg <= shift_reg_n;
      tx_serial <= serial_n;
      tx_ready  <= ready_n;
      busy      <= busy_n;
`ifdef SERIAL_TX_PARITY_EN
      par_bit   <= par_bit_n;
`endif
    end
  end

  // Outputs are registered, so each branch computes the line level for the
  // cycle that follows the edge on which the state changes.
  always_comb begin
    state_n     = state;
    clk_cnt_n   = clk_cnt;
    bit_cnt_n   = bit_cnt;
    shift_reg_n = shift_reg;
    serial_n    = tx_serial;
    ready_n     = tx_ready;
    busy_n      = busy;
`ifdef SERIAL_TX_PARITY_EN
    par_bit_n   = par_bit;
`endif
    case (state)
      IDLE: begin
        serial_n = 1'b1;
        ready_n  = 1'b1;
        busy_n   = 1'b0;
        if (tx_valid && tx_ready) begin
          state_n     = START;
          shift_reg_n = tx_data;
          clk_cnt_n   = '0;
          bit_cnt_n   = '0;
          serial_n    = 1'b0;
          ready_n     = 1'b0;
          busy_n      = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
          // Captured here because the shift register is consumed bit by bit.
          par_bit_n   = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_done) begin
          state_n   = DATA;
          clk_cnt_n = '0;
          serial_n  = shift_reg[0];
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          clk_cnt_n = '0;
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
            state_n  = PARITY;
            serial_n = par_bit;
`else
            state_n  = STOP;
            serial_n = 1'b1;
`endif
          end else begin
            shift_reg_n = shift_nxt;
            bit_cnt_n   = bit_cnt + 1'b1;
            serial_n    = shift_nxt[0];
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_n   = STOP;
          clk_cnt_n = '0;
          serial_n  = 1'b1;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_n   = IDLE;
          clk_cnt_n = '0;
          serial_n  = 1'b1;
          ready_n   = 1'b1;
          busy_n    = 1'b0;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      default: begin
        state_n  = IDLE;
        serial_n = 1'b1;
        ready_n  = 1'b1;
        busy_n   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed bench for serial_tx with a bit-level scoreboard.
//   Two instances: u_dut (CLKS_PER_BIT=4) and u_dut1 (CLKS_PER_BIT=1).
//   Honours SERIAL_TX_PARITY_EN in its frame model.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_ready, a_serial, a_busy;
  logic       b_ready, b_serial, b_busy;

  int n_assert = 0;
  int n_fail   = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .tx_serial(a_serial), .busy(a_busy)
  );

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .tx_serial(b_serial), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line levels, one entry per clock cycle of the frame.
  task automatic push_frame(input logic [7:0] d, input int cpb);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef SERIAL_TX_PARITY_EN
    bits.push_back(^d);
`endif
    bits.push_back(1'b1);
    foreach (bits[k])
      for (int r = 0; r < cpb; r++) exp_q.push_back(bits[k]);
  endtask

  // Starts at a negedge with u_dut idle; handshake happens on the next edge.
  task automatic run_a(input logic [7:0] d, input bit hold, input bit disturb,
                       input logic [7:0] late_data);
    int n;
    bit e;
    a_data  = d;
    a_valid = 1'b1;
    push_frame(d, 4);
    @(negedge clk);
    if (!hold) a_valid = 1'b0;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("a_serial[%0d] d=%0h", i, d), a_serial, e);
      chk("a_busy_in_frame", a_busy, 1);
      chk("a_ready_in_frame", a_ready, 0);
      if (i == 2) a_data = late_data;
      if (disturb && i == 5) begin a_valid = 1'b1; a_data = 8'hFF; end
      if (disturb && i == 6) a_valid = 1'b0;
      @(negedge clk);
    end
    chk("a_ready_after_frame", a_ready, 1);
    chk("a_busy_after_frame", a_busy, 0);
    chk("a_serial_after_frame", a_serial, 1);
  endtask

  initial begin
    int n;
    bit e;
    reset_n = 1'b0;
    a_valid = 1'b0; a_data = 8'h00;
    b_valid = 1'b0; b_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_a_serial", a_serial, 1);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_b_serial", b_serial, 1);
    chk("rst_b_busy", b_busy, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame
    run_a(8'hA5, 1'b0, 1'b0, 8'hA5);
    @(negedge clk);

    // Data hold: tx_data changes and a tx_valid pulse mid-frame are ignored
    run_a(8'h3C, 1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 12; i++) begin
      chk("hold_no_second_busy", a_busy, 0);
      chk("hold_no_second_serial", a_serial, 1);
      @(negedge clk);
    end

    // Back-to-back with tx_valid held
    run_a(8'h01, 1'b1, 1'b0, 8'h80);
    run_a(8'h80, 1'b0, 1'b0, 8'h80);
    @(negedge clk);

`ifdef SERIAL_TX_PARITY_EN
    run_a(8'h07, 1'b0, 1'b0, 8'h07);
    @(negedge clk);
`endif

    // One cycle per bit
    b_data  = 8'h00;
    b_valid = 1'b1;
    push_frame(8'h00, 1);
    @(negedge clk);
    b_valid = 1'b0;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("b_serial[%0d]", i), b_serial, e);
      chk("b_busy_in_frame", b_busy, 1);
      @(negedge clk);
    end
    chk("b_busy_after_frame", b_busy, 0);
    chk("b_ready_after_frame", b_ready, 1);
    chk("b_serial_after_frame", b_serial, 1);

    // Reset mid-frame
    a_data  = 8'hFF;
    a_valid = 1'b1;
    @(negedge clk);
    repeat (6) @(negedge clk);
    chk("midframe_busy", a_busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_serial", a_serial, 1);
    chk("midrst_ready", a_ready, 1);
    chk("midrst_busy", a_busy, 0);
    @(negedge clk);
    chk("midrst2_serial", a_serial, 1);
    chk("midrst2_busy", a_busy, 0);
    a_valid = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("postrst_serial", a_serial, 1);
      chk("postrst_busy", a_busy, 0);
      chk("postrst_ready", a_ready, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
